// File: rtl/lc3b_control_pkg.sv
// Shared LC-3b control types: opcode and ALU-op enums plus datapath mux-select codes.
package lc3b_control_pkg;

  localparam int unsigned OPCODE_W = 4;
  localparam int unsigned ALUOP_W  = 3;
  localparam int unsigned SEL2_W   = 2;

  typedef enum logic [OPCODE_W-1:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldr  = 4'b0110,
    op_str  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode;

  typedef enum logic [ALUOP_W-1:0] {
    alu_add  = 3'd0,
    alu_and  = 3'd1,
    alu_not  = 3'd2,
    alu_pass = 3'd3,
    alu_sll  = 3'd4,
    alu_srl  = 3'd5,
    alu_sra  = 3'd6
  } lc3b_aluop;

  // pcmux: next PC source
  localparam logic [SEL2_W-1:0] PCMUX_PC2      = 2'd0;
  localparam logic [SEL2_W-1:0] PCMUX_PCOFF9   = 2'd1;
  localparam logic [SEL2_W-1:0] PCMUX_SR1      = 2'd2;
  localparam logic [SEL2_W-1:0] PCMUX_PCOFF11  = 2'd3;

  // marmux: MAR source
  localparam logic MARMUX_ALU = 1'b0;
  localparam logic MARMUX_PC  = 1'b1;

  // alumux: ALU operand B source
  localparam logic [SEL2_W-1:0] ALUMUX_SR2     = 2'd0;
  localparam logic [SEL2_W-1:0] ALUMUX_OFF6    = 2'd1;
  localparam logic [SEL2_W-1:0] ALUMUX_IMM5    = 2'd2;
  localparam logic [SEL2_W-1:0] ALUMUX_IMM4    = 2'd3;

  // regfilemux: register write-back source
  localparam logic [SEL2_W-1:0] RFMUX_ALU      = 2'd0;
  localparam logic [SEL2_W-1:0] RFMUX_MDR      = 2'd1;
  localparam logic [SEL2_W-1:0] RFMUX_PC       = 2'd2;
  localparam logic [SEL2_W-1:0] RFMUX_PCOFF9   = 2'd3;

  // destmux / storemux / mdrmux
  localparam logic DESTMUX_IR  = 1'b0;
  localparam logic DESTMUX_R7  = 1'b1;
  localparam logic STOREMUX_SR1 = 1'b0;
  localparam logic STOREMUX_DR  = 1'b1;
  localparam logic MDRMUX_ALU  = 1'b0;
  localparam logic MDRMUX_MEM  = 1'b1;

endpackage

// File: rtl/lc3b_control.sv
// Multicycle LC-3b control FSM: fetch -> decode -> execute, one instruction at a time.
// Inputs : clk, rst_n (async, active low), opcode/ir11/A/D (IR fields),
//          branch_enable (nzp & cc), mem_resp (single-cycle access-done pulse).
// Outputs: register load enables, datapath mux selects, aluop, mem_read/mem_write.
//          Moore outputs decoded from the state register (selects may also use A/D/ir11),
//          so they drop to zero the moment rst_n is asserted.
module lc3b_control
  import lc3b_control_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  lc3b_opcode          opcode,
  input  logic                ir11,
  input  logic                A,
  input  logic                D,
  input  logic                branch_enable,
  input  logic                mem_resp,
  output logic                load_pc,
  output logic                load_ir,
  output logic                load_regfile,
  output logic                load_mar,
  output logic                load_mdr,
  output logic                load_cc,
  output logic [SEL2_W-1:0]   pcmux_sel,
  output logic                marmux_sel,
  output logic [SEL2_W-1:0]   alumux_sel,
  output logic [SEL2_W-1:0]   regfilemux_sel,
  output logic                destmux_sel,
  output logic                storemux_sel,
  output logic                mdrmux_sel,
  output lc3b_aluop           aluop,
  output logic                mem_read,
  output logic                mem_write
);

  typedef enum logic [4:0] {
    S_IDLE,
    S_FETCH1,
    S_FETCH2,
    S_FETCH3,
    S_DECODE,
    S_ADD,
    S_AND,
    S_NOT,
    S_SHF,
    S_LEA,
    S_BR,
    S_BR_TAKEN,
    S_JMP,
    S_JSR,
    S_CALC_ADDR,
    S_LDR1,
    S_LDR2,
    S_STR1,
    S_STR2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; mem_resp only matters in the three memory-wait states
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:      w_next_state = S_FETCH1;
      S_FETCH1:    w_next_state = S_FETCH2;
      S_FETCH2:    if (mem_resp) w_next_state = S_FETCH3;
      S_FETCH3:    w_next_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          op_add:         w_next_state = S_ADD;
          op_and:         w_next_state = S_AND;
          op_not:         w_next_state = S_NOT;
          op_shf:         w_next_state = S_SHF;
          op_lea:         w_next_state = S_LEA;
          op_br:          w_next_state = S_BR;
          op_jmp:         w_next_state = S_JMP;
          op_jsr:         w_next_state = S_JSR;
          op_ldr, op_str: w_next_state = S_CALC_ADDR;
          // Unsupported opcodes retire as NOPs
          default:        w_next_state = S_FETCH1;
        endcase
      end
      S_BR:        w_next_state = branch_enable ? S_BR_TAKEN : S_FETCH1;
      S_CALC_ADDR: w_next_state = (opcode == op_ldr) ? S_LDR1 : S_STR1;
      S_LDR1:      if (mem_resp) w_next_state = S_LDR2;
      S_STR1:      w_next_state = S_STR2;
      S_STR2:      if (mem_resp) w_next_state = S_FETCH1;
      S_ADD, S_AND, S_NOT, S_SHF, S_LEA, S_BR_TAKEN, S_JMP, S_JSR, S_LDR2:
                   w_next_state = S_FETCH1;
      default:     w_next_state = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    load_pc        = 1'b0;
    load_ir        = 1'b0;
    load_regfile   = 1'b0;
    load_mar       = 1'b0;
    load_mdr       = 1'b0;
    load_cc        = 1'b0;
    pcmux_sel      = PCMUX_PC2;
    marmux_sel     = MARMUX_ALU;
    alumux_sel     = ALUMUX_SR2;
    regfilemux_sel = RFMUX_ALU;
    destmux_sel    = DESTMUX_IR;
    storemux_sel   = STOREMUX_SR1;
    mdrmux_sel     = MDRMUX_ALU;
    aluop          = alu_add;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    case (r_state)
      S_FETCH1: begin
        marmux_sel = MARMUX_PC;
        load_mar   = 1'b1;
        pcmux_sel  = PCMUX_PC2;
        load_pc    = 1'b1;
      end
      S_FETCH2, S_LDR1: begin
        mem_read   = 1'b1;
        mdrmux_sel = MDRMUX_MEM;
        load_mdr   = 1'b1;
      end
      S_FETCH3: load_ir = 1'b1;
      S_ADD: begin
        alumux_sel   = A ? ALUMUX_IMM5 : ALUMUX_SR2;
        aluop        = alu_add;
        load_regfile = 1'b1;
        load_cc      = 1'b1;
      end
      S_AND: begin
        alumux_sel   = A ? ALUMUX_IMM5 : ALUMUX_SR2;
        aluop        = alu_and;
        load_regfile = 1'b1;
        load_cc      = 1'b1;
      end
      S_NOT: begin
        aluop        = alu_not;
        load_regfile = 1'b1;
        load_cc      = 1'b1;
      end
      S_SHF: begin
        alumux_sel   = ALUMUX_IMM4;
        // D selects direction; A selects arithmetic vs logical right shift
        aluop        = !D ? alu_sll : (A ? alu_sra : alu_srl);
        load_regfile = 1'b1;
        load_cc      = 1'b1;
      end
      S_LEA: begin
        regfilemux_sel = RFMUX_PCOFF9;
        load_regfile   = 1'b1;
        load_cc        = 1'b1;
      end
      S_BR_TAKEN: begin
        pcmux_sel = PCMUX_PCOFF9;
        load_pc   = 1'b1;
      end
      S_JMP: begin
        pcmux_sel = PCMUX_SR1;
        load_pc   = 1'b1;
      end
      S_JSR: begin
        // R7 <= PC and PC <= target share one edge, so JSRR R7 sees the old R7
        regfilemux_sel = RFMUX_PC;
        destmux_sel    = DESTMUX_R7;
        load_regfile   = 1'b1;
        load_pc        = 1'b1;
        pcmux_sel      = ir11 ? PCMUX_PCOFF11 : PCMUX_SR1;
      end
      S_CALC_ADDR: begin
        alumux_sel = ALUMUX_OFF6;
        aluop      = alu_add;
        marmux_sel = MARMUX_ALU;
        load_mar   = 1'b1;
      end
      S_LDR2: begin
        regfilemux_sel = RFMUX_MDR;
        load_regfile   = 1'b1;
        load_cc        = 1'b1;
      end
      S_STR1: begin
        storemux_sel = STOREMUX_DR;
        aluop        = alu_pass;
        mdrmux_sel   = MDRMUX_ALU;
        load_mdr     = 1'b1;
      end
      S_STR2: mem_write = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lc3b_control.sv
// Directed self-checking bench for lc3b_control. All outputs are packed into one
// vector and compared per state against hand-built expected vectors.
module tb_lc3b_control;
  import lc3b_control_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  lc3b_opcode  opcode;
  logic        ir11, A, D, branch_enable, mem_resp;
  logic        load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc;
  logic [1:0]  pcmux_sel, alumux_sel, regfilemux_sel;
  logic        marmux_sel, destmux_sel, storemux_sel, mdrmux_sel;
  lc3b_aluop   aluop;
  logic        mem_read, mem_write;

  int n_checks = 0;
  int n_fail   = 0;

  logic [20:0] v_zero, v_f1, v_f2, v_f3, e;

  lc3b_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .ir11(ir11), .A(A), .D(D),
    .branch_enable(branch_enable), .mem_resp(mem_resp),
    .load_pc(load_pc), .load_ir(load_ir), .load_regfile(load_regfile),
    .load_mar(load_mar), .load_mdr(load_mdr), .load_cc(load_cc),
    .pcmux_sel(pcmux_sel), .marmux_sel(marmux_sel), .alumux_sel(alumux_sel),
    .regfilemux_sel(regfilemux_sel), .destmux_sel(destmux_sel),
    .storemux_sel(storemux_sel), .mdrmux_sel(mdrmux_sel), .aluop(aluop),
    .mem_read(mem_read), .mem_write(mem_write)
  );

  always #5 clk = ~clk;

  wire [20:0] obs = {load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc,
                     pcmux_sel, marmux_sel, alumux_sel, regfilemux_sel,
                     destmux_sel, storemux_sel, mdrmux_sel, aluop, mem_read, mem_write};

  // Expected-vector builder, argument order matches obs
  function automatic logic [20:0] mk(input int lpc, lir, lrf, lmar, lmdr, lcc,
                                     input int pcm, marm, alum, rfm, dm, sm, mdrm,
                                     input int op, rd, wr);
    return {1'(lpc), 1'(lir), 1'(lrf), 1'(lmar), 1'(lmdr), 1'(lcc),
            2'(pcm), 1'(marm), 2'(alum), 2'(rfm), 1'(dm), 1'(sm), 1'(mdrm),
            3'(op), 1'(rd), 1'(wr)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From FETCH1, run the fetch with `waits` extra memory cycles; ends in DECODE
  task automatic do_fetch(input int waits);
    tick();
    repeat (waits) tick();
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (obs !== v_zero) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected %h", obs, v_zero);
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (obs !== v_f1) begin
      n_fail++; $display("FAIL first_fetch1: got %h expected %h", obs, v_f1);
    end
  endtask

  task automatic test_add_imm();
    int rd_cycles = 0;
    opcode = op_add; A = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (mem_read === 1'b1) rd_cycles++;
      if (i == 3) mem_resp = 1'b1;
      tick();
    end
    mem_resp = 1'b0;
    n_checks++;
    if (rd_cycles != 4) begin
      n_fail++; $display("FAIL add_fetch_wait: got %0d expected 4 read cycles", rd_cycles);
    end
    n_checks++;
    if (obs !== v_f3) begin
      n_fail++; $display("FAIL add_fetch3: got %h expected %h", obs, v_f3);
    end
    tick();
    n_checks++;
    if (obs !== v_zero) begin
      n_fail++; $display("FAIL add_decode: got %h expected %h", obs, v_zero);
    end
    tick();
    e = mk(0,0,1,0,0,1, 0,0,2,0,0,0,0, alu_add,0,0);
    n_checks++;
    if (obs !== e) begin
      n_fail++; $display("FAIL add_exec: got %h expected %h", obs, e);
    end
    tick();
    n_checks++;
    if (obs !== v_f1) begin
      n_fail++; $display("FAIL add_return: got %h expected %h", obs, v_f1);
    end
  endtask

  task automatic test_branch();
    int pc_off9 = 0;
    opcode = op_br; branch_enable = 1'b0;
    do_fetch(0);
    tick();
    n_checks++;
    if (obs !== v_zero) begin
      n_fail++; $display("FAIL br_nt_state: got %h expected %h", obs, v_zero);
    end
    tick();
    n_checks++;
    if (obs !== v_f1) begin
      n_fail++; $display("FAIL br_nt_return: got %h expected %h", obs, v_f1);
    end
    branch_enable = 1'b1;
    do_fetch(0);
    tick();
    n_checks++;
    if (obs !== v_zero) begin
      n_fail++; $display("FAIL br_t_state: got %h expected %h", obs, v_zero);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      if (load_pc === 1'b1 && pcmux_sel === 2'd1) pc_off9++;
    end
    n_checks++;
    if (pc_off9 != 1) begin
      n_fail++; $display("FAIL br_taken_pulses: got %0d expected 1", pc_off9);
    end
    n_checks++;
    if (obs !== v_f1) begin
      n_fail++; $display("FAIL br_t_return: got %h expected %h", obs, v_f1);
    end
    branch_enable = 1'b0;
  endtask

  task automatic test_ldr_str();
    logic [20:0] exp_l [7];
    logic [20:0] exp_s [7];
    exp_l[0] = v_f1; exp_l[1] = v_f2; exp_l[2] = v_f3; exp_l[3] = v_zero;
    exp_l[4] = mk(0,0,0,1,0,0, 0,0,1,0,0,0,0, alu_add,0,0);
    exp_l[5] = v_f2;
    exp_l[6] = mk(0,0,1,0,0,1, 0,0,0,1,0,0,0, alu_add,0,0);
    exp_s[0] = v_f1; exp_s[1] = v_f2; exp_s[2] = v_f3; exp_s[3] = v_zero;
    exp_s[4] = exp_l[4];
    exp_s[5] = mk(0,0,0,0,1,0, 0,0,0,0,0,1,0, alu_pass,0,0);
    exp_s[6] = mk(0,0,0,0,0,0, 0,0,0,0,0,0,0, alu_add,0,1);
    // Memory answers in the first cycle each strobe is seen
    opcode = op_ldr;
    for (int i = 0; i < 7; i++) begin
      n_checks++;
      if (obs !== exp_l[i]) begin
        n_fail++; $display("FAIL ldr_step%0d: got %h expected %h", i, obs, exp_l[i]);
      end
      mem_resp = mem_read | mem_write;
      tick();
      mem_resp = 1'b0;
    end
    n_checks++;
    if (obs !== v_f1) begin
      n_fail++; $display("FAIL ldr_length: got %h expected %h", obs, v_f1);
    end
    opcode = op_str;
    for (int i = 0; i < 7; i++) begin
      n_checks++;
      if (obs !== exp_s[i]) begin
        n_fail++; $display("FAIL str_step%0d: got %h expected %h", i, obs, exp_s[i]);
      end
      mem_resp = mem_read | mem_write;
      tick();
      mem_resp = 1'b0;
    end
    n_checks++;
    if (obs !== v_f1) begin
      n_fail++; $display("FAIL str_length: got %h expected %h", obs, v_f1);
    end
  endtask

  task automatic test_exec_ops();
    lc3b_opcode  t_op [10];
    logic        t_a  [10];
    logic        t_d  [10];
    logic        t_j  [10];
    logic [20:0] t_e  [10];
    t_op[0] = op_add; t_a[0] = 0; t_d[0] = 0; t_j[0] = 0;
    t_e[0]  = mk(0,0,1,0,0,1, 0,0,0,0,0,0,0, alu_add,0,0);
    t_op[1] = op_and; t_a[1] = 1; t_d[1] = 0; t_j[1] = 0;
    t_e[1]  = mk(0,0,1,0,0,1, 0,0,2,0,0,0,0, alu_and,0,0);
    t_op[2] = op_not; t_a[2] = 0; t_d[2] = 0; t_j[2] = 0;
    t_e[2]  = mk(0,0,1,0,0,1, 0,0,0,0,0,0,0, alu_not,0,0);
    t_op[3] = op_shf; t_a[3] = 1; t_d[3] = 0; t_j[3] = 0;
    t_e[3]  = mk(0,0,1,0,0,1, 0,0,3,0,0,0,0, alu_sll,0,0);
    t_op[4] = op_shf; t_a[4] = 0; t_d[4] = 1; t_j[4] = 0;
    t_e[4]  = mk(0,0,1,0,0,1, 0,0,3,0,0,0,0, alu_srl,0,0);
    t_op[5] = op_shf; t_a[5] = 1; t_d[5] = 1; t_j[5] = 0;
    t_e[5]  = mk(0,0,1,0,0,1, 0,0,3,0,0,0,0, alu_sra,0,0);
    t_op[6] = op_lea; t_a[6] = 0; t_d[6] = 0; t_j[6] = 0;
    t_e[6]  = mk(0,0,1,0,0,1, 0,0,0,3,0,0,0, alu_add,0,0);
    t_op[7] = op_jmp; t_a[7] = 0; t_d[7] = 0; t_j[7] = 0;
    t_e[7]  = mk(1,0,0,0,0,0, 2,0,0,0,0,0,0, alu_add,0,0);
    t_op[8] = op_jsr; t_a[8] = 0; t_d[8] = 0; t_j[8] = 0;
    t_e[8]  = mk(1,0,1,0,0,0, 2,0,0,2,1,0,0, alu_add,0,0);
    t_op[9] = op_jsr; t_a[9] = 0; t_d[9] = 0; t_j[9] = 1;
    t_e[9]  = mk(1,0,1,0,0,0, 3,0,0,2,1,0,0, alu_add,0,0);
    for (int i = 0; i < 10; i++) begin
      opcode = t_op[i]; A = t_a[i]; D = t_d[i]; ir11 = t_j[i];
      do_fetch(0);
      tick();
      n_checks++;
      if (obs !== t_e[i]) begin
        n_fail++; $display("FAIL exec_op%0d: got %h expected %h", i, obs, t_e[i]);
      end
      tick();
      n_checks++;
      if (obs !== v_f1) begin
        n_fail++; $display("FAIL exec_op%0d_return: got %h expected %h", i, obs, v_f1);
      end
    end
    A = 1'b0; D = 1'b0; ir11 = 1'b0;
  endtask

  task automatic test_trap_nop();
    opcode = op_trap;
    do_fetch(1);
    // A stray mem_resp in DECODE has no effect
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0;
    n_checks++;
    if (obs !== v_f1) begin
      n_fail++; $display("FAIL trap_nop: got %h expected %h", obs, v_f1);
    end
  endtask

  task automatic test_reset_mid_access();
    opcode = op_ldr;
    do_fetch(0);
    tick();
    tick();
    n_checks++;
    if (obs !== v_f2) begin
      n_fail++; $display("FAIL ldr1_before_reset: got %h expected %h", obs, v_f2);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (mem_read !== 1'b0) begin
      n_fail++; $display("FAIL async_read_drop: got %b expected 0", mem_read);
    end
    n_checks++;
    if (obs !== v_zero) begin
      n_fail++; $display("FAIL async_reset_outs: got %h expected %h", obs, v_zero);
    end
    tick();
    rst_n = 1'b1;
    n_checks++;
    if (obs !== v_zero) begin
      n_fail++; $display("FAIL restart_idle: got %h expected %h", obs, v_zero);
    end
    tick();
    n_checks++;
    if (obs !== v_f1) begin
      n_fail++; $display("FAIL restart_fetch1: got %h expected %h", obs, v_f1);
    end
  endtask

  initial begin
    rst_n = 1'b0; opcode = op_br; ir11 = 1'b0; A = 1'b0; D = 1'b0;
    branch_enable = 1'b0; mem_resp = 1'b0;
    v_zero = mk(0,0,0,0,0,0, 0,0,0,0,0,0,0, alu_add,0,0);
    v_f1   = mk(1,0,0,1,0,0, 0,1,0,0,0,0,0, alu_add,0,0);
    v_f2   = mk(0,0,0,0,1,0, 0,0,0,0,0,0,1, alu_add,1,0);
    v_f3   = mk(0,1,0,0,0,0, 0,0,0,0,0,0,0, alu_add,0,0);
    e      = v_zero;
    test_reset();
    test_add_imm();
    test_branch();
    test_ldr_str();
    test_exec_ops();
    test_trap_nop();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
